// File: rtl/bht_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bht_pkg
// Description : Shared types and helpers for the branch history table
//               controller: FSM state encoding, update-queue entry layout and
//               the saturating counter step.
// Revision    : 1.0 - initial release
// ============================================================================
package bht_pkg;

    // Default geometry; the controller exposes these as overridable parameters.
    localparam int BHT_IDX_W     = 6;
    localparam int BHT_CTR_W     = 2;
    // Widest counter the shared helper supports; callers zero-extend into it.
    localparam int BHT_CTR_MAX_W = 8;

    typedef enum logic {
        BHT_INIT = 1'b0,
        BHT_RUN  = 1'b1
    } bht_state_e;

    // Layout of one queued update: index in the upper bits, outcome in bit 0.
    typedef struct packed {
        logic [BHT_IDX_W-1:0] idx;
        logic                 taken;
    } upd_entry_t;

    localparam int BHT_UPD_ENTRY_W = $bits(upd_entry_t);

    // Saturating up/down step; ctr_max is the all-ones value of the real width
    // so one function serves every counter width up to BHT_CTR_MAX_W.
    function automatic logic [BHT_CTR_MAX_W-1:0] sat_step(
        input logic [BHT_CTR_MAX_W-1:0] ctr,
        input logic                     taken,
        input logic [BHT_CTR_MAX_W-1:0] ctr_max
    );
        logic [BHT_CTR_MAX_W-1:0] res;
        res = ctr;
        if (taken && (ctr != ctr_max)) begin
            res = ctr + BHT_CTR_MAX_W'(1);
        end else if (!taken && (ctr != '0)) begin
            res = ctr - BHT_CTR_MAX_W'(1);
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bht_update_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bht_update_fifo
// Description : Small synchronous FIFO buffering resolved-branch updates.
//               Wrap-bit pointers distinguish full from empty; a synchronous
//               clear empties it without touching the storage.
// Revision    : 1.0 - initial release
// ============================================================================
module bht_update_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] pop_data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;

    assign empty_o    = (wr_ptr_q == rd_ptr_q);
    assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_data_o = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer bookkeeping; clear and reset both return to empty.
    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i && !full_o) begin
                wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
            end
            if (pop_i && !empty_o) begin
                rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    // Storage write; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_i && !full_o) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bht_controller.sv
`default_nettype none
// ============================================================================
// Module      : bht_controller
// Description : Branch history table of saturating counters. Arbitrates one
//               table access per cycle between fetch lookups and queued
//               execute updates, and walks a clear over the whole table after
//               reset or flush.
// Revision    : 1.0 - initial release
// ============================================================================
module bht_controller #(
    parameter int IDX_W     = 6,
    parameter int CTR_W     = 2,
    parameter int UPQ_DEPTH = 2,
    parameter int CTR_INIT  = (1 << (CTR_W - 1)) - 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             lookup_valid_i,
    input  logic [IDX_W-1:0] lookup_idx_i,
    output logic             lookup_ready_o,
    output logic             pred_valid_o,
    output logic             pred_taken_o,
    output logic [CTR_W-1:0] pred_ctr_o,
    input  logic             update_valid_i,
    input  logic [IDX_W-1:0] update_idx_i,
    input  logic             update_taken_i,
    output logic             update_ready_o,
    output logic             busy_o
);

    import bht_pkg::*;

    localparam int               ENTRIES    = 1 << IDX_W;
    localparam int               ENTRY_W    = IDX_W + 1;
    localparam logic [IDX_W-1:0] PTR_LAST   = '1;
    localparam logic [CTR_W-1:0] CTR_ALL1   = '1;
    localparam logic [CTR_W-1:0] CTR_INIT_V = CTR_W'(CTR_INIT);

    bht_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [CTR_W-1:0] table_q [ENTRIES];
    logic             pred_valid_q;
    logic [CTR_W-1:0] pred_ctr_q;

    logic               w_run;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_lookup_fire;
    logic [ENTRY_W-1:0] w_push_data;
    logic [ENTRY_W-1:0] w_pop_data;
    logic [IDX_W-1:0]   w_pop_idx;
    logic               w_pop_taken;
    logic [CTR_W-1:0]   w_new_ctr;

    assign w_run          = (state_q == BHT_RUN);
    assign busy_o         = (state_q == BHT_INIT);
    assign lookup_ready_o = w_run && !flush_i && !w_full;
    assign update_ready_o = w_run && !flush_i && !w_full;
    assign w_lookup_fire  = lookup_valid_i && lookup_ready_o;
    assign w_push         = update_valid_i && update_ready_o;
    // A full queue takes the table port; otherwise lookups win and updates
    // drain only in idle cycles. Flush cycles do nothing but start the clear.
    assign w_pop          = w_run && !flush_i && !w_empty &&
                            (w_full || !lookup_valid_i);

    assign w_push_data    = {update_idx_i, update_taken_i};
    assign w_pop_idx      = w_pop_data[ENTRY_W-1:1];
    assign w_pop_taken    = w_pop_data[0];
    assign w_new_ctr      = CTR_W'(sat_step(BHT_CTR_MAX_W'(table_q[w_pop_idx]),
                                            w_pop_taken,
                                            BHT_CTR_MAX_W'(CTR_ALL1)));

    assign pred_valid_o   = pred_valid_q;
    assign pred_ctr_o     = pred_ctr_q;
    assign pred_taken_o   = pred_ctr_q[CTR_W-1];

    bht_update_fifo #(
        .DEPTH (UPQ_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_upq (
        .clk         (clk),
        .reset       (reset),
        .clear_i     (flush_i),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_i       (w_pop),
        .pop_data_o  (w_pop_data),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    // State and clear-pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BHT_INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Next state: the clear visits every entry once, a flush restarts it.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            BHT_INIT: begin
                if (flush_i) begin
                    ptr_d = '0;
                end else if (ptr_q == PTR_LAST) begin
                    state_d = BHT_RUN;
                    ptr_d   = '0;
                end else begin
                    ptr_d = ptr_q + IDX_W'(1);
                end
            end
            BHT_RUN: begin
                if (flush_i) begin
                    state_d = BHT_INIT;
                    ptr_d   = '0;
                end
            end
        endcase
    end

    // Table writes: clear stores the init value, otherwise a popped update
    // completes its read-modify-write in the pop cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state_q == BHT_INIT) begin
                table_q[ptr_q] <= CTR_INIT_V;
            end else if (w_pop) begin
                table_q[w_pop_idx] <= w_new_ctr;
            end
        end
    end

    // Prediction register: one-cycle lookup latency, value held when idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            pred_valid_q <= 1'b0;
            pred_ctr_q   <= '0;
        end else begin
            pred_valid_q <= w_lookup_fire;
            if (w_lookup_fire) begin
                pred_ctr_q <= table_q[lookup_idx_i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bht_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_bht_controller
// Description : Self-checking bench for bht_controller: table-driven
//               update/lookup vectors plus hand-written arbitration, flush
//               and reset sequences; predictions are matched against a queue
//               of expected counter values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bht_controller;

    localparam int IDX_W = 6;
    localparam int CTR_W = 2;
    localparam int NVEC  = 16;

    logic             clk;
    logic             reset;
    logic             flush_i;
    logic             lookup_valid_i;
    logic [IDX_W-1:0] lookup_idx_i;
    logic             lookup_ready_o;
    logic             pred_valid_o;
    logic             pred_taken_o;
    logic [CTR_W-1:0] pred_ctr_o;
    logic             update_valid_i;
    logic [IDX_W-1:0] update_idx_i;
    logic             update_taken_i;
    logic             update_ready_o;
    logic             busy_o;

    bht_controller #(
        .IDX_W     (IDX_W),
        .CTR_W     (CTR_W),
        .UPQ_DEPTH (2),
        .CTR_INIT  (1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .flush_i        (flush_i),
        .lookup_valid_i (lookup_valid_i),
        .lookup_idx_i   (lookup_idx_i),
        .lookup_ready_o (lookup_ready_o),
        .pred_valid_o   (pred_valid_o),
        .pred_taken_o   (pred_taken_o),
        .pred_ctr_o     (pred_ctr_o),
        .update_valid_i (update_valid_i),
        .update_idx_i   (update_idx_i),
        .update_taken_i (update_taken_i),
        .update_ready_o (update_ready_o),
        .busy_o         (busy_o)
    );

    typedef struct {
        bit               is_lookup;
        logic [IDX_W-1:0] idx;
        logic             taken;
        logic [CTR_W-1:0] exp_ctr;
    } vec_t;

    vec_t             vecs [NVEC];
    logic [CTR_W-1:0] exp_q [$];
    logic [CTR_W-1:0] mon_e;
    int               n_cmp = 0;
    int               n_err = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer: every valid prediction must match the oldest
    // expected value pushed when its lookup was accepted.
    always @(negedge clk) begin
        if (pred_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("pred_valid_unexpected", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("pred_ctr", 32'(pred_ctr_o), 32'(mon_e));
                check("pred_taken", 32'(pred_taken_o), 32'(mon_e[CTR_W-1]));
            end
        end
    end

    task automatic do_lookup(input logic [IDX_W-1:0] idx, input logic [CTR_W-1:0] exp);
        int n;
        n = 0;
        lookup_valid_i = 1'b1;
        lookup_idx_i   = idx;
        #3;
        while (lookup_ready_o !== 1'b1 && n < 20) begin
            tick();
            #3;
            n++;
        end
        if (lookup_ready_o !== 1'b1) check("lookup_accept_timeout", 32'd0, 32'd1);
        else exp_q.push_back(exp);
        tick();
        lookup_valid_i = 1'b0;
    endtask

    // Push one update, then leave one idle cycle so it drains.
    task automatic do_update(input logic [IDX_W-1:0] idx, input logic taken);
        int n;
        n = 0;
        update_valid_i = 1'b1;
        update_idx_i   = idx;
        update_taken_i = taken;
        #3;
        while (update_ready_o !== 1'b1 && n < 20) begin
            tick();
            #3;
            n++;
        end
        if (update_ready_o !== 1'b1) check("update_accept_timeout", 32'd0, 32'd1);
        tick();
        update_valid_i = 1'b0;
        tick();
    endtask

    // Called in the first clear cycle: counts clear length, checks readies low.
    task automatic count_busy(input string name);
        int cnt;
        int bad;
        cnt = 0;
        bad = 0;
        while (busy_o === 1'b1 && cnt < 200) begin
            if (lookup_ready_o !== 1'b0 || update_ready_o !== 1'b0) bad++;
            cnt++;
            tick();
        end
        check(name, 32'(cnt), 32'd64);
        check({name, "_ready_low"}, 32'(bad), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{1'b0, 6'd9,  1'b1, 2'd0};
        vecs[1]  = '{1'b0, 6'd9,  1'b1, 2'd0};
        vecs[2]  = '{1'b0, 6'd9,  1'b1, 2'd0};
        vecs[3]  = '{1'b1, 6'd9,  1'b0, 2'd3};
        vecs[4]  = '{1'b0, 6'd9,  1'b1, 2'd0};
        vecs[5]  = '{1'b1, 6'd9,  1'b0, 2'd3};
        vecs[6]  = '{1'b0, 6'd9,  1'b0, 2'd0};
        vecs[7]  = '{1'b0, 6'd9,  1'b0, 2'd0};
        vecs[8]  = '{1'b0, 6'd9,  1'b0, 2'd0};
        vecs[9]  = '{1'b0, 6'd9,  1'b0, 2'd0};
        vecs[10] = '{1'b1, 6'd9,  1'b0, 2'd0};
        vecs[11] = '{1'b1, 6'd10, 1'b0, 2'd1};
        vecs[12] = '{1'b0, 6'd10, 1'b0, 2'd0};
        vecs[13] = '{1'b1, 6'd10, 1'b0, 2'd0};
        vecs[14] = '{1'b1, 6'd63, 1'b0, 2'd1};
        vecs[15] = '{1'b1, 6'd0,  1'b0, 2'd1};

        reset          = 1'b1;
        flush_i        = 1'b0;
        lookup_valid_i = 1'b0;
        lookup_idx_i   = '0;
        update_valid_i = 1'b0;
        update_idx_i   = '0;
        update_taken_i = 1'b0;
        tick();
        tick();
        tick();

        // Reset values
        check("rst_busy", 32'(busy_o), 32'd1);
        check("rst_lookup_ready", 32'(lookup_ready_o), 32'd0);
        check("rst_update_ready", 32'(update_ready_o), 32'd0);
        check("rst_pred_valid", 32'(pred_valid_o), 32'd0);
        check("rst_pred_ctr", 32'(pred_ctr_o), 32'd0);
        check("rst_pred_taken", 32'(pred_taken_o), 32'd0);

        // Initial clear: 64 cycles, then ready
        reset = 1'b0;
        count_busy("init_clear_cycles");
        check("post_clear_busy", 32'(busy_o), 32'd0);
        check("post_clear_lookup_ready", 32'(lookup_ready_o), 32'd1);
        do_lookup(6'd5, 2'd1);

        // Table-driven saturation vectors
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].is_lookup) do_lookup(vecs[i].idx, vecs[i].exp_ctr);
            else do_update(vecs[i].idx, vecs[i].taken);
        end

        // Arbitration: lookups win until the queue fills
        lookup_valid_i = 1'b1;
        lookup_idx_i   = 6'd20;
        update_valid_i = 1'b1;
        update_idx_i   = 6'd21;
        update_taken_i = 1'b1;
        #3;
        check("arb_a_lookup_ready", 32'(lookup_ready_o), 32'd1);
        check("arb_a_update_ready", 32'(update_ready_o), 32'd1);
        if (lookup_ready_o === 1'b1) exp_q.push_back(2'd1);
        tick();
        #3;
        check("arb_b_lookup_ready", 32'(lookup_ready_o), 32'd1);
        check("arb_b_update_ready", 32'(update_ready_o), 32'd1);
        if (lookup_ready_o === 1'b1) exp_q.push_back(2'd1);
        tick();
        update_valid_i = 1'b0;
        #3;
        check("arb_full_lookup_ready", 32'(lookup_ready_o), 32'd0);
        check("arb_full_update_ready", 32'(update_ready_o), 32'd0);
        tick();
        lookup_idx_i = 6'd21;
        #3;
        check("arb_resume_lookup_ready", 32'(lookup_ready_o), 32'd1);
        if (lookup_ready_o === 1'b1) exp_q.push_back(2'd2);
        tick();
        lookup_valid_i = 1'b0;
        tick();
        do_lookup(6'd21, 2'd3);

        // No forwarding from the queue
        lookup_valid_i = 1'b1;
        lookup_idx_i   = 6'd3;
        update_valid_i = 1'b1;
        update_idx_i   = 6'd3;
        update_taken_i = 1'b1;
        #3;
        check("nofwd_lookup_ready", 32'(lookup_ready_o), 32'd1);
        check("nofwd_update_ready", 32'(update_ready_o), 32'd1);
        if (lookup_ready_o === 1'b1) exp_q.push_back(2'd1);
        tick();
        lookup_valid_i = 1'b0;
        update_valid_i = 1'b0;
        tick();
        do_lookup(6'd3, 2'd2);

        // Flush in RUN drops a queued update
        do_update(6'd7, 1'b1);
        do_update(6'd7, 1'b1);
        do_lookup(6'd7, 2'd3);
        update_valid_i = 1'b1;
        update_idx_i   = 6'd7;
        update_taken_i = 1'b0;
        #3;
        check("flush_q_update_ready", 32'(update_ready_o), 32'd1);
        tick();
        update_valid_i = 1'b0;
        flush_i        = 1'b1;
        lookup_valid_i = 1'b1;
        lookup_idx_i   = 6'd7;
        #3;
        check("flush_busy_same_cycle", 32'(busy_o), 32'd0);
        check("flush_lookup_ready", 32'(lookup_ready_o), 32'd0);
        check("flush_update_ready", 32'(update_ready_o), 32'd0);
        tick();
        flush_i        = 1'b0;
        lookup_valid_i = 1'b0;
        count_busy("run_flush_clear_cycles");
        do_lookup(6'd7, 2'd1);
        check("pred_hold_valid", 32'(pred_valid_o), 32'd1);
        tick();
        check("pred_idle_valid", 32'(pred_valid_o), 32'd0);
        check("pred_hold_ctr", 32'(pred_ctr_o), 32'd1);

        // Flush during INIT restarts the clear
        do_update(6'd10, 1'b1);
        do_update(6'd10, 1'b1);
        do_lookup(6'd10, 2'd3);
        do_update(6'd40, 1'b0);
        do_lookup(6'd40, 2'd0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        check("init_flush_busy_at_ptr30", 32'(busy_o), 32'd1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        count_busy("init_flush_restart_cycles");
        do_lookup(6'd10, 2'd1);
        do_lookup(6'd40, 2'd1);
        do_lookup(6'd30, 2'd1);

        // Reset mid-operation overrides a pending lookup and update
        lookup_valid_i = 1'b1;
        lookup_idx_i   = 6'd5;
        update_valid_i = 1'b1;
        update_idx_i   = 6'd5;
        update_taken_i = 1'b1;
        reset          = 1'b1;
        tick();
        lookup_valid_i = 1'b0;
        update_valid_i = 1'b0;
        check("midrst_pred_valid", 32'(pred_valid_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd1);
        check("midrst_pred_ctr", 32'(pred_ctr_o), 32'd0);
        reset = 1'b0;
        count_busy("midrst_clear_cycles");
        do_lookup(6'd9, 2'd1);

        tick();
        tick();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
